// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: state encoding and default widths.
package fetch_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int TIMER_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/fetch_timer.sv
// Counts FETCH cycles spent waiting for imem_ack; expired flags the last allowed cycle.
module fetch_timer
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clock,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // High during the TIMEOUT-th FETCH cycle; an ack in that same cycle still wins.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: fetches at pc, holds ir during execute, updates pc on retire.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0]  RST_VEC = '0,
    parameter int unsigned        TIMEOUT = 8
) (
    input  logic              clock,
    input  logic              n_rst,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ex_done,
    input  logic              br_sel,
    input  logic              imr_sel,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs,
    input  logic              halt,
    input  logic              resume,
    output logic [DATA_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err,
    output logic [DATA_W-1:0] retire_cnt,
    output state_t            state_dbg
);

    // Handshakes: imem_req is held with a stable imem_addr until an imem_ack cycle
    // transfers imem_rdata; ir_valid is held until an ex_done cycle retires ir.

    state_t            state;
    logic              tmr_expired;
    logic [DATA_W-1:0] next_pc;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .n_rst   (n_rst),
        .clear   (state != ST_FETCH),
        .enable  (state == ST_FETCH),
        .expired (tmr_expired)
    );

    always_comb begin
        next_pc = pc + DATA_W'(1);
        if (br_sel) begin
            next_pc = imr_sel ? rs : (pc + imm + DATA_W'(1));
        end
    end

    // Status outputs are registered alongside state, so imem_ack never reaches imem_req combinationally.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            pc         <= RST_VEC;
            ir         <= '0;
            retire_cnt <= '0;
            imem_req   <= 1'b0;
            ir_valid   <= 1'b0;
            halted     <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_rdata;
                        state    <= ST_EXEC;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                    end else if (tmr_expired) begin
                        state     <= ST_ERR;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        pc         <= next_pc;
                        retire_cnt <= retire_cnt + DATA_W'(1);
                        ir_valid   <= 1'b0;
                        if (halt) begin
                            state  <= ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state    <= ST_FETCH;
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign state_dbg = state;

endmodule
